// File: rtl/wfa_pkg.sv
// Shared types and helpers for the wavefront reduce stage.
// Lane words are {k signed, offset[15:0]}.
package wfa_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CAP,
    S_SCAN1,
    S_SCAN2,
    S_UPD
  } state_t;

  localparam logic [15:0] NULL_OFFSET = 16'hFFFF;
  localparam int PROG_W = 19;

  function automatic logic [15:0] lane_offset(
    input logic [31:0] w
  );
    return w[15:0];
  endfunction

  // Sign-extends the kw-bit diagonal field above the offset.
  function automatic logic signed [PROG_W-1:0] lane_k(
    input logic [31:0] w,
    input int          kw
  );
    logic signed [31:0] t;
    t = $signed((w >> 16) << (32 - kw));
    t = t >>> (32 - kw);
    return t[PROG_W-1:0];
  endfunction

  function automatic logic signed [PROG_W-1:0] progress(
    input logic        [15:0]       off,
    input logic signed [PROG_W-1:0] k
  );
    return $signed({2'b00, off, 1'b0}) - k;
  endfunction

endpackage

// File: rtl/lane_mux.sv
// Selects one lane word from the captured lane vector.
module lane_mux #(
  parameter int FIFO_WIDTH = 30,
  parameter int NUM_EXTEND = 8
) (
  input  logic [FIFO_WIDTH*NUM_EXTEND-1:0] lanes,
  input  logic [$clog2(NUM_EXTEND)-1:0]    sel,
  output logic [FIFO_WIDTH-1:0]            word
);

  assign word = lanes[sel*FIFO_WIDTH +: FIFO_WIDTH];

endmodule

// File: rtl/wavefront_reduce.sv
// Captures the extend lanes, streams them to DBRAM and reduces
// the wavefront to a new diagonal range with X-drop trimming.
module wavefront_reduce
  import wfa_pkg::*;
#(
  parameter int FIFO_WIDTH    = 30,
  parameter int NUM_EXTEND    = 8,
  parameter int TILE_SIZE     = 512,
  parameter int LOG_TILE_SIZE = $clog2(TILE_SIZE),
  parameter int ADDR_WIDTH    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  input  logic [15:0]                    drop,
  input  logic [15:0]                    ref_len,
  input  logic [15:0]                    query_len,
  input  logic [FIFO_WIDTH*NUM_EXTEND-1:0] ext_offset,
  input  logic [NUM_EXTEND-1:0]          ext_valid,
  output logic                           ext_read,
  output logic                           bram_wen,
  output logic [15:0]                    bram_din,
  output logic [ADDR_WIDTH-1:0]          bram_addr,
  output logic signed [LOG_TILE_SIZE:0]  kmin,
  output logic signed [LOG_TILE_SIZE:0]  kmax,
  output logic [15:0]                    score,
  output logic                           busy,
  output logic                           done,
  output logic                           hit,
  output logic                           empty
);

  localparam int IW = $clog2(NUM_EXTEND);
  localparam int KW = FIFO_WIDTH - 16;
  localparam int OW = LOG_TILE_SIZE + 1;
  localparam logic signed [PROG_W-1:0] PMIN =
    {1'b1, {(PROG_W-1){1'b0}}};

  state_t state;
  logic [FIFO_WIDTH*NUM_EXTEND-1:0] cap;
  logic [IW-1:0] idx;
  logic [FIFO_WIDTH-1:0] lane;
  logic [15:0] off;
  logic signed [PROG_W-1:0] k, p, pmax;
  logic signed [PROG_W-1:0] smin, smax, nmin, nmax;
  logic [PROG_W-1:0] gap;
  logic any_surv, nsurv, is_null, survive, hit_lane;

  lane_mux #(
    .FIFO_WIDTH(FIFO_WIDTH),
    .NUM_EXTEND(NUM_EXTEND)
  ) u_mux (
    .lanes(cap),
    .sel  (idx),
    .word (lane)
  );

  always_comb begin
    off      = lane_offset(32'(lane));
    k        = lane_k(32'(lane), KW);
    p        = progress(off, k);
    is_null  = (off == NULL_OFFSET);
    gap      = pmax - p;
    survive  = !is_null && (gap <= {3'b000, drop});
    hit_lane = !is_null && (off >= ref_len) &&
      (($signed({3'b000, off}) - k) >=
        $signed({3'b000, query_len}));
    nsurv    = any_surv | survive;
    nmin     = smin;
    nmax     = smax;
    if (survive && (!any_surv || k < smin)) nmin = k;
    if (survive && (!any_surv || k > smax)) nmax = k;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cap       <= '0;
      idx       <= '0;
      pmax      <= '0;
      smin      <= '0;
      smax      <= '0;
      any_surv  <= 1'b0;
      ext_read  <= 1'b0;
      bram_wen  <= 1'b0;
      bram_din  <= '0;
      bram_addr <= '0;
      kmin      <= '0;
      kmax      <= '0;
      score     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit       <= 1'b0;
      empty     <= 1'b0;
    end else begin
      ext_read <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_WAIT;
            busy  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (&ext_valid) begin
            cap      <= ext_offset;
            idx      <= '0;
            ext_read <= 1'b1;
            state    <= S_CAP;
          end
        end
        S_CAP: begin
          bram_wen  <= 1'b1;
          bram_addr <= base_addr;
          bram_din  <= off;
          pmax      <= is_null ? PMIN : p;
          any_surv  <= 1'b0;
          if (hit_lane) hit <= 1'b1;
          idx       <= idx + IW'(1);
          state     <= S_SCAN1;
        end
        S_SCAN1: begin
          // idx wraps to zero once every lane has been written
          if (idx == '0) begin
            bram_wen <= 1'b0;
            state    <= S_SCAN2;
          end else begin
            bram_addr <= bram_addr + ADDR_WIDTH'(1);
            bram_din  <= off;
            if (!is_null && p > pmax) pmax <= p;
            if (hit_lane) hit <= 1'b1;
            idx <= idx + IW'(1);
          end
        end
        S_SCAN2: begin
          smin     <= nmin;
          smax     <= nmax;
          any_surv <= nsurv;
          idx      <= idx + IW'(1);
          if (idx == IW'(NUM_EXTEND - 1)) begin
            if (nsurv) begin
              kmin <= nmin[OW-1:0];
              kmax <= nmax[OW-1:0];
            end
            empty <= !nsurv;
            score <= score + 16'd1;
            done  <= 1'b1;
            state <= S_UPD;
          end
        end
        S_UPD: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wavefront_reduce.sv
// Directed and randomized rounds against an arithmetic model
// of the wavefront reduction.
module tb_wavefront_reduce;
  localparam int N  = 8;
  localparam int FW = 30;
  localparam int AW = 16;
  localparam int LT = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [15:0] drop = '0;
  logic [15:0] ref_len = 16'hFFFF;
  logic [15:0] query_len = 16'hFFFF;
  logic [FW*N-1:0] ext_offset = '0;
  logic [N-1:0] ext_valid = '0;
  logic ext_read, bram_wen, busy, done, hit, empty;
  logic [15:0] bram_din, score;
  logic [AW-1:0] bram_addr;
  logic signed [LT:0] kmin, kmax;

  wavefront_reduce #(
    .FIFO_WIDTH(FW), .NUM_EXTEND(N), .TILE_SIZE(512),
    .LOG_TILE_SIZE(LT), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .drop(drop),
    .ref_len(ref_len), .query_len(query_len),
    .ext_offset(ext_offset), .ext_valid(ext_valid),
    .ext_read(ext_read), .bram_wen(bram_wen),
    .bram_din(bram_din), .bram_addr(bram_addr),
    .kmin(kmin), .kmax(kmax), .score(score),
    .busy(busy), .done(done), .hit(hit), .empty(empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int lk[N];
  int lo[N];
  int m_kmin = 0, m_kmax = 0, m_score = 0;
  int m_hit = 0, m_empty = 0;

  task automatic check(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++)
      ext_offset[i*FW +: FW] = {14'(lk[i]), 16'(lo[i])};
  endtask

  // Reference: progress = 2*offset - k, survivors within drop of the best.
  task automatic model_round();
    int pmax, mn, mx, p;
    bit any;
    any = 0; mn = 0; mx = 0;
    pmax = -(1 << 30);
    for (int i = 0; i < N; i++) begin
      if (lo[i] == 65535) continue;
      p = 2 * lo[i] - lk[i];
      if (p > pmax) pmax = p;
      if (lo[i] >= int'(ref_len) && lo[i] - lk[i] >= int'(query_len))
        m_hit = 1;
    end
    for (int i = 0; i < N; i++) begin
      if (lo[i] == 65535) continue;
      p = 2 * lo[i] - lk[i];
      if (pmax - p <= int'(drop)) begin
        if (!any || lk[i] < mn) mn = lk[i];
        if (!any || lk[i] > mx) mx = lk[i];
        any = 1;
      end
    end
    if (any) begin
      m_kmin = mn; m_kmax = mx; m_empty = 0;
    end else m_empty = 1;
    m_score = (m_score + 1) % 65536;
  endtask

  task automatic run_round(input int d, input string nm);
    int read_n, read_at, wr_n, first_wr, done_n, done_at, idle_at;
    read_n = 0; read_at = -1; wr_n = 0; first_wr = -1;
    done_n = 0; done_at = -1; idle_at = -1;
    pack();
    ext_valid = (d > 0) ? 8'h7F : 8'hFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({nm, "_busy"}, 32'(busy), 1);
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (ext_read) begin read_n++; read_at = c; end
      if (bram_wen) begin
        if (wr_n == 0) first_wr = c;
        if (wr_n < N) begin
          check({nm, "_addr"}, 32'(bram_addr),
                (int'(base_addr) + wr_n) % 65536);
          check({nm, "_din"}, 32'(bram_din), lo[wr_n]);
        end
        wr_n++;
      end
      if (done) begin done_n++; done_at = c; end
      if (c == d) ext_valid = 8'hFF;
      if (c == d + 1) begin
        for (int i = 0; i < N; i++)
          ext_offset[i*FW +: FW] = FW'($urandom);
        ext_valid = N'($urandom);
      end
      if (!busy) begin idle_at = c; break; end
    end
    model_round();
    check({nm, "_read_n"}, read_n, 1);
    check({nm, "_read_at"}, read_at, d + 1);
    check({nm, "_wr_n"}, wr_n, N);
    check({nm, "_first_wr"}, first_wr, d + 2);
    check({nm, "_done_n"}, done_n, 1);
    check({nm, "_done_at"}, done_at, d + 2 * N + 2);
    check({nm, "_idle_at"}, idle_at, d + 2 * N + 3);
    check({nm, "_kmin"}, $signed(kmin), m_kmin);
    check({nm, "_kmax"}, $signed(kmax), m_kmax);
    check({nm, "_score"}, 32'(score), m_score);
    check({nm, "_empty"}, 32'(empty), m_empty);
    check({nm, "_hit"}, 32'(hit), m_hit);
    ext_valid = '0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_wen", 32'(bram_wen), 0);
    check("rst_read", 32'(ext_read), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_score", 32'(score), 0);
    check("rst_kmin", $signed(kmin), 0);
    check("rst_hit", 32'(hit), 0);
    check("rst_empty", 32'(empty), 0);
    rst = 1'b0;

    // reset while lane 3 is being written
    for (int i = 0; i < N; i++) begin lk[i] = i - 3; lo[i] = 10; end
    base_addr = 16'd100; drop = 16'd100;
    pack();
    ext_valid = 8'hFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_wen_pre", 32'(bram_wen), 1);
    check("mid_addr_pre", 32'(bram_addr), 103);
    rst = 1'b1;
    #1;
    check("mid_wen", 32'(bram_wen), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_score", 32'(score), 0);
    check("mid_done", 32'(done), 0);
    ext_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_no_done", 32'(done), 0);

    run_round(0, "A");

    drop = 16'd2;
    run_round(0, "B");

    for (int i = 0; i < N; i++) lo[i] = 65535;
    drop = 16'd100;
    run_round(0, "C");

    for (int i = 0; i < N; i++) lo[i] = 5;
    lo[5] = 20;
    ref_len = 16'd20; query_len = 16'd18;
    run_round(0, "D");

    for (int i = 0; i < N; i++) lo[i] = 7;
    base_addr = 16'hFFFC;
    run_round(5, "E");

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N; i++) begin
        lk[i] = int'($urandom_range(400)) - 200;
        lo[i] = ($urandom_range(5) == 0) ? 65535
              : int'($urandom_range(3000));
      end
      base_addr = AW'($urandom);
      drop      = 16'($urandom_range(3000));
      ref_len   = 16'($urandom_range(3500));
      query_len = 16'($urandom_range(3500));
      run_round(int'($urandom_range(3)), "R");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
